// File: rtl/vga_pixel_capture_if.sv
// Signal bundle between the VGA pin side and the frame-buffer writer.
// The driver (pins/bench) uses the master modport; the capture block uses the slave modport.
interface vga_pixel_capture_if;
    logic        hsync;
    logic        vsync;
    logic [11:0] vga_in;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [10:0] pixel_x;
    logic [9:0]  line_y;
    logic        line_done;
    logic        phase_err;
    logic        ovf_err;

    modport master (
        output hsync,
        output vsync,
        output vga_in,
        input  pixel_data,
        input  pixel_valid,
        input  pixel_x,
        input  line_y,
        input  line_done,
        input  phase_err,
        input  ovf_err
    );

    modport slave (
        input  hsync,
        input  vsync,
        input  vga_in,
        output pixel_data,
        output pixel_valid,
        output pixel_x,
        output line_y,
        output line_done,
        output phase_err,
        output ovf_err
    );
endinterface

// File: rtl/vga_pixel_capture.sv
// Pairs 12-bit half-words sampled on pixel_clk_2x into 24-bit pixels (high half first),
// tags them with column/line coordinates and flags odd-length or overlong lines.
module vga_pixel_capture #(
    parameter int H_PIXELS = 1024,
    parameter int V_LINES  = 768
) (
    input  logic                  pixel_clk_2x,
    input  logic                  reset,
    vga_pixel_capture_if.slave    bus
);

    localparam logic [10:0] COL_MAX   = 11'(H_PIXELS);
    localparam logic [9:0]  LAST_LINE = 10'(V_LINES - 1);

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic        hsync_p1, hsync_p2;
    logic        vsync_p1, vsync_p2;
    logic [11:0] vga_p1;

    logic [11:0] hi_reg;
    logic [10:0] col_cnt;

    logic        latch_hi;
    logic        emit;
    logic        ovf_nxt;
    logic        phase_nxt;

    logic        line_end;
    logic        frame_start;
    logic        col_full;

    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [10:0] pixel_x;
    logic [9:0]  line_y;
    logic        line_done;
    logic        phase_err;
    logic        ovf_err;

    // ---- stage p1: pin registers; stage p2: previous sync levels for edge detection ----
    always_ff @(posedge pixel_clk_2x or posedge reset) begin
        if (reset) begin
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
            vga_p1   <= '0;
            hsync_p2 <= 1'b0;
            vsync_p2 <= 1'b0;
        end else begin
            hsync_p1 <= bus.hsync;
            vsync_p1 <= bus.vsync;
            vga_p1   <= bus.vga_in;
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
        end
    end

    assign line_end    = ~hsync_p1 & hsync_p2;
    assign frame_start = vsync_p1 & ~vsync_p2;
    assign col_full    = (col_cnt == COL_MAX);

    // ---- pairing FSM: state register ----
    always_ff @(posedge pixel_clk_2x or posedge reset) begin
        if (reset) begin
            state <= ST_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HI:   if (hsync_p1) state_nxt = ST_LO;
            ST_LO:   state_nxt = ST_HI;
            default: state_nxt = ST_HI;
        endcase
    end

    // A LO state always follows a sampled-high hsync, so a low hsync here means
    // the window closed on an unpaired high half.
    always_comb begin
        latch_hi  = 1'b0;
        emit      = 1'b0;
        ovf_nxt   = 1'b0;
        phase_nxt = 1'b0;
        case (state)
            ST_HI: begin
                latch_hi = hsync_p1;
            end
            ST_LO: begin
                if (hsync_p1) begin
                    if (col_full) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end else begin
                    phase_nxt = 1'b1;
                end
            end
            default: begin
                latch_hi = 1'b0;
            end
        endcase
    end

    // ---- stage p3: assembled pixel, coordinates and status pulses ----
    always_ff @(posedge pixel_clk_2x or posedge reset) begin
        if (reset) begin
            hi_reg      <= '0;
            pixel_data  <= '0;
            pixel_x     <= '0;
            pixel_valid <= 1'b0;
            ovf_err     <= 1'b0;
            phase_err   <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            if (latch_hi) begin
                hi_reg <= vga_p1;
            end
            if (emit) begin
                pixel_data <= {hi_reg, vga_p1};
                pixel_x    <= col_cnt;
            end
            pixel_valid <= emit;
            ovf_err     <= ovf_nxt;
            phase_err   <= phase_nxt;
            line_done   <= line_end;
        end
    end

    // Column count saturates at the line limit; only a line end clears it.
    always_ff @(posedge pixel_clk_2x or posedge reset) begin
        if (reset) begin
            col_cnt <= '0;
        end else if (line_end) begin
            col_cnt <= '0;
        end else if (emit) begin
            col_cnt <= col_cnt + 11'd1;
        end
    end

    // Frame start overrides a coincident line increment.
    always_ff @(posedge pixel_clk_2x or posedge reset) begin
        if (reset) begin
            line_y <= '0;
        end else if (frame_start) begin
            line_y <= '0;
        end else if (line_end) begin
            line_y <= (line_y == LAST_LINE) ? 10'd0 : line_y + 10'd1;
        end
    end

    assign bus.pixel_data  = pixel_data;
    assign bus.pixel_valid = pixel_valid;
    assign bus.pixel_x     = pixel_x;
    assign bus.line_y      = line_y;
    assign bus.line_done   = line_done;
    assign bus.phase_err   = phase_err;
    assign bus.ovf_err     = ovf_err;

endmodule

// File: tb/tb_vga_pixel_capture.sv
// Scoreboard bench for vga_pixel_capture: directed lines push expected strobe events,
// a negedge monitor pops and compares each cycle any output strobe is high.
module tb_vga_pixel_capture;

    localparam int H = 1024;
    localparam int V = 768;

    typedef struct packed {
        logic        v;
        logic        o;
        logic        p;
        logic        d;
        logic [23:0] data;
        logic [10:0] x;
        logic [9:0]  y;
    } ev_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   exp_y;
    logic prev_valid;

    ev_t         exp_q[$];
    logic [11:0] hv[$];

    vga_pixel_capture_if bus();

    vga_pixel_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
        .pixel_clk_2x(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic h, input logic [11:0] v, input logic vs);
        bus.hsync  = h;
        bus.vga_in = v;
        bus.vsync  = vs;
        @(negedge clk);
    endtask

    task automatic push_ev(input logic v, input logic o, input logic p, input logic d,
                           input logic [23:0] data, input logic [10:0] x, input logic [9:0] y);
        ev_t e;
        e.v = v; e.o = o; e.p = p; e.d = d;
        e.data = data; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    // Sends the halves in hv as one active window, optionally with a vsync rise on the falling edge.
    task automatic send_line(input bit vs_end);
        int np;
        np = hv.size() / 2;
        for (int k = 0; k < np; k++) begin
            if (k < H) push_ev(1'b1, 1'b0, 1'b0, 1'b0, {hv[2*k], hv[2*k+1]}, 11'(k), 10'd0);
            else       push_ev(1'b0, 1'b1, 1'b0, 1'b0, 24'd0, 11'd0, 10'd0);
        end
        exp_y = vs_end ? 0 : ((exp_y == V - 1) ? 0 : exp_y + 1);
        push_ev(1'b0, 1'b0, 1'(hv.size() % 2), 1'b1, 24'd0, 11'd0, 10'(exp_y));
        for (int i = 0; i < hv.size(); i++) drive(1'b1, hv[i], 1'b0);
        drive(1'b0, 12'd0, vs_end);
        drive(1'b0, 12'd0, 1'b0);
        drive(1'b0, 12'd0, 1'b0);
    endtask

    task automatic fill_count(input int n, input logic [11:0] base);
        hv.delete();
        for (int i = 0; i < n; i++) hv.push_back(base + 12'(i));
    endtask

    // Monitor: one expected event per cycle with any strobe high.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pixel_valid) chk("valid_spacing", {31'd0, prev_valid}, 32'd0);
            if (bus.pixel_valid | bus.ovf_err | bus.phase_err | bus.line_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe",
                        {28'd0, bus.pixel_valid, bus.ovf_err, bus.phase_err, bus.line_done}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("strobes", {28'd0, bus.pixel_valid, bus.ovf_err, bus.phase_err, bus.line_done},
                        {28'd0, e.v, e.o, e.p, e.d});
                    if (e.v) begin
                        chk("pixel_data", {8'd0, bus.pixel_data}, {8'd0, e.data});
                        chk("pixel_x", {21'd0, bus.pixel_x}, {21'd0, e.x});
                    end
                    if (e.d) chk("line_y", {22'd0, bus.line_y}, {22'd0, e.y});
                end
            end
            prev_valid <= bus.pixel_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        tests = 0;
        fails = 0;
        exp_y = 0;
        prev_valid = 1'b0;
        reset = 1'b1;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        bus.vga_in = 12'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pixel_valid", {31'd0, bus.pixel_valid}, 32'd0);
        chk("rst_pixel_data", {8'd0, bus.pixel_data}, 32'd0);
        chk("rst_pixel_x", {21'd0, bus.pixel_x}, 32'd0);
        chk("rst_line_y", {22'd0, bus.line_y}, 32'd0);
        chk("rst_pulses", {29'd0, bus.line_done, bus.phase_err, bus.ovf_err}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 12'd0, 1'b0);
        drive(1'b0, 12'd0, 1'b0);

        // Single pixel
        hv.delete();
        hv.push_back(12'hFF0);
        hv.push_back(12'h0AA);
        send_line(1'b0);
        chk("single_line_y", {22'd0, bus.line_y}, 32'd1);

        // Full line of 1024 pixels
        fill_count(2048, 12'd0);
        send_line(1'b0);

        // Odd half count, then a clean short line
        fill_count(5, 12'h300);
        send_line(1'b0);
        fill_count(4, 12'h400);
        send_line(1'b0);

        // Overflow: 1026 pairs against a 1024-pixel limit
        fill_count(2052, 12'd0);
        send_line(1'b0);
        chk("ovf_line_y", {22'd0, bus.line_y}, 32'd5);

        // Frame start on its own clears line_y
        drive(1'b0, 12'd0, 1'b1);
        drive(1'b0, 12'd0, 1'b0);
        drive(1'b0, 12'd0, 1'b0);
        exp_y = 0;
        chk("vsync_clear_y", {22'd0, bus.line_y}, 32'd0);

        // Full frame wraps line_y back to 0
        for (int l = 0; l < V; l++) begin
            hv.delete();
            hv.push_back(12'(l));
            hv.push_back(~12'(l));
            send_line(1'b0);
        end
        chk("frame_wrap_y", {22'd0, bus.line_y}, 32'd0);

        for (int l = 0; l < 10; l++) begin
            fill_count(2, 12'h500 + 12'(2 * l));
            send_line(1'b0);
        end
        chk("ten_lines_y", {22'd0, bus.line_y}, 32'd10);

        // vsync rise coincident with the hsync fall: clear wins
        fill_count(2, 12'h6A0);
        send_line(1'b1);
        chk("vsync_coincident_y", {22'd0, bus.line_y}, 32'd0);
        fill_count(2, 12'h6B0);
        send_line(1'b0);
        chk("post_coincident_y", {22'd0, bus.line_y}, 32'd1);

        // Reset mid-line after 3 pixels with hsync held high
        fill_count(6, 12'h700);
        for (int k = 0; k < 3; k++)
            push_ev(1'b1, 1'b0, 1'b0, 1'b0, {hv[2*k], hv[2*k+1]}, 11'(k), 10'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, hv[i], 1'b0);
        drive(1'b1, 12'h706, 1'b0);
        bus.vga_in = 12'h707;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_pixel_valid", {31'd0, bus.pixel_valid}, 32'd0);
        chk("midrst_pixel_data", {8'd0, bus.pixel_data}, 32'd0);
        chk("midrst_pixel_x", {21'd0, bus.pixel_x}, 32'd0);
        chk("midrst_line_y", {22'd0, bus.line_y}, 32'd0);
        exp_y = 0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        fill_count(4, 12'h800);
        send_line(1'b0);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
